// File: rtl/multicycle_alu_sequencer.sv
// Control FSM for the multicycle datapath.
// Walks each instruction through fetch, decode, execute, memory and write-back.
// Drives every datapath enable, the ALU operand selects and the ALU operation.
//
// state        | meaning
// -------------+---------------------------------------------------------
// RESET    (0) | idle after reset, all outputs low
// FETCH    (1) | read instruction at PC, PC <= PC + 4
// FETCH_WAIT(2)| memory read latency, load IR
// DECODE   (3) | precompute branch target into ALUOut, dispatch on opcode
// MEM_ADDR (4) | ALUOut <= A + sign_extend (lw/sw/addm)
// MEM_RD   (5) | read data memory at ALUOut
// MEM_RD_WAIT(6)| memory read latency, load MDR
// LW_WB    (7) | rt <= MDR
// SW       (8) | write data memory at ALUOut
// RTYPE_EX (9) | ALUOut <= A op B
// RTYPE_WB (10)| rd <= ALUOut
// ADDI_EX  (11)| ALUOut <= A + sign_extend
// ADDI_WB  (12)| rt <= ALUOut
// BEQ      (13)| compare A - B, branch to ALUOut when zero
// JUMP     (14)| PC <= jump target
// ADDM_EX  (15)| ALUOut <= A + MDR
// ADDM_WB  (16)| rt <= ALUOut
// HALT     (17)| illegal instruction, parked until reset
//
// Outputs are registered from the next-state decode, so they always match
// the state register. pc_en is the only output that also looks at zero,
// and only BEQ asserts the conditional PC write.
module multicycle_alu_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [4:0] state,
    output logic       illegal,
    output logic       alu_src_a,
    output logic [2:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       pc_en,
    output logic [1:0] pc_source,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mdr_write,
    output logic       aluout_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg
);

    typedef enum logic [4:0] {
        S_RESET       = 5'd0,
        S_FETCH       = 5'd1,
        S_FETCH_WAIT  = 5'd2,
        S_DECODE      = 5'd3,
        S_MEM_ADDR    = 5'd4,
        S_MEM_RD      = 5'd5,
        S_MEM_RD_WAIT = 5'd6,
        S_LW_WB       = 5'd7,
        S_SW          = 5'd8,
        S_RTYPE_EX    = 5'd9,
        S_RTYPE_WB    = 5'd10,
        S_ADDI_EX     = 5'd11,
        S_ADDI_WB     = 5'd12,
        S_BEQ         = 5'd13,
        S_JUMP        = 5'd14,
        S_ADDM_EX     = 5'd15,
        S_ADDM_WB     = 5'd16,
        S_HALT        = 5'd17
    } state_t;

    typedef struct packed {
        logic       illegal;
        logic       alu_src_a;
        logic [2:0] alu_src_b;
        logic [2:0] alu_op;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mdr_write;
        logic       aluout_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDM  = 6'h01;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [2:0] ALU_IDLE = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;
    localparam logic [2:0] ALU_OR   = 3'd4;

    state_t r_state;
    ctrl_t  r_ctrl;
    state_t w_next;

    function automatic logic [2:0] f_rtype_op(input logic [5:0] f);
        case (f)
            6'h20:   return ALU_ADD;
            6'h22:   return ALU_SUB;
            6'h24:   return ALU_AND;
            6'h25:   return ALU_OR;
            default: return ALU_IDLE;
        endcase
    endfunction

    function automatic state_t f_next(input state_t s, input logic [5:0] op,
                                      input logic [5:0] f);
        case (s)
            S_RESET:      return S_FETCH;
            S_FETCH:      return S_FETCH_WAIT;
            S_FETCH_WAIT: return S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_RTYPE: return (f_rtype_op(f) != ALU_IDLE) ? S_RTYPE_EX : S_HALT;
                    OP_ADDI:  return S_ADDI_EX;
                    OP_LW, OP_SW, OP_ADDM: return S_MEM_ADDR;
                    OP_BEQ:   return S_BEQ;
                    OP_J:     return S_JUMP;
                    default:  return S_HALT;
                endcase
            end
            S_MEM_ADDR:    return (op == OP_SW) ? S_SW : S_MEM_RD;
            S_MEM_RD:      return S_MEM_RD_WAIT;
            S_MEM_RD_WAIT: begin
                if (op == OP_LW)        return S_LW_WB;
                else if (op == OP_ADDM) return S_ADDM_EX;
                else                    return S_HALT;
            end
            S_RTYPE_EX:    return S_RTYPE_WB;
            S_ADDI_EX:     return S_ADDI_WB;
            S_ADDM_EX:     return S_ADDM_WB;
            S_LW_WB, S_SW, S_RTYPE_WB, S_ADDI_WB,
            S_BEQ, S_JUMP, S_ADDM_WB: return S_FETCH;
            default:       return S_HALT;
        endcase
    endfunction

    // funct is only consulted when entering RTYPE_EX; IR is frozen by then.
    function automatic ctrl_t f_decode(input state_t s, input logic [5:0] f);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = 3'd1;
                c.alu_op    = ALU_ADD;
                c.pc_write  = 1'b1;
            end
            S_FETCH_WAIT: c.ir_write = 1'b1;
            S_DECODE: begin
                c.alu_src_b    = 3'd3;
                c.alu_op       = ALU_ADD;
                c.aluout_write = 1'b1;
            end
            S_MEM_ADDR, S_ADDI_EX: begin
                c.alu_src_a    = 1'b1;
                c.alu_src_b    = 3'd2;
                c.alu_op       = ALU_ADD;
                c.aluout_write = 1'b1;
            end
            S_MEM_RD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            S_MEM_RD_WAIT: c.mdr_write = 1'b1;
            S_LW_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_SW: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            S_RTYPE_EX: begin
                c.alu_src_a    = 1'b1;
                c.alu_op       = f_rtype_op(f);
                c.aluout_write = 1'b1;
            end
            S_RTYPE_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_ADDI_WB, S_ADDM_WB: c.reg_write = 1'b1;
            S_BEQ: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = ALU_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'd1;
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'd2;
            end
            S_ADDM_EX: begin
                c.alu_src_a    = 1'b1;
                c.alu_src_b    = 3'd4;
                c.alu_op       = ALU_ADD;
                c.aluout_write = 1'b1;
            end
            S_HALT:  c.illegal = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    assign w_next = f_next(r_state, opcode, funct);

    // State register and registered output decode of the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_RESET;
            r_ctrl  <= '0;
        end else begin
            r_state <= w_next;
            r_ctrl  <= f_decode(w_next, funct);
        end
    end

    assign state        = r_state;
    assign illegal      = r_ctrl.illegal;
    assign alu_src_a    = r_ctrl.alu_src_a;
    assign alu_src_b    = r_ctrl.alu_src_b;
    assign alu_op       = r_ctrl.alu_op;
    assign pc_en        = r_ctrl.pc_write | (r_ctrl.pc_write_cond & zero);
    assign pc_source    = r_ctrl.pc_source;
    assign iord         = r_ctrl.iord;
    assign mem_read     = r_ctrl.mem_read;
    assign mem_write    = r_ctrl.mem_write;
    assign ir_write     = r_ctrl.ir_write;
    assign mdr_write    = r_ctrl.mdr_write;
    assign aluout_write = r_ctrl.aluout_write;
    assign reg_write    = r_ctrl.reg_write;
    assign reg_dst      = r_ctrl.reg_dst;
    assign mem_to_reg   = r_ctrl.mem_to_reg;

endmodule

// File: tb/tb_multicycle_alu_sequencer.sv
// Bench for multicycle_alu_sequencer: per-cycle vector table plus corner sequences.
module tb_multicycle_alu_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic [4:0] state;
    logic       illegal, alu_src_a, pc_en, iord, mem_read, mem_write;
    logic       ir_write, mdr_write, aluout_write, reg_write, reg_dst, mem_to_reg;
    logic [2:0] alu_src_b, alu_op;
    logic [1:0] pc_source;

    int checks = 0;
    int errors = 0;

    multicycle_alu_sequencer dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .state(state), .illegal(illegal), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_en(pc_en),
        .pc_source(pc_source), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .mdr_write(mdr_write),
        .aluout_write(aluout_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg)
    );

    always #5 clk = ~clk;

    // {illegal, src_a, src_b[2:0], alu_op[2:0], pc_en, pc_source[1:0],
    //  iord, mem_read, mem_write, ir_write, mdr_write, aluout_write,
    //  reg_write, reg_dst, mem_to_reg}
    logic [19:0] obs;
    assign obs = {illegal, alu_src_a, alu_src_b, alu_op, pc_en, pc_source,
                  iord, mem_read, mem_write, ir_write, mdr_write, aluout_write,
                  reg_write, reg_dst, mem_to_reg};

    localparam logic [19:0] E_ZERO    = 20'b0_0_000_000_0_00_0_0_0_0_0_0_0_0_0;
    localparam logic [19:0] E_FETCH   = 20'b0_0_001_001_1_00_0_1_0_0_0_0_0_0_0;
    localparam logic [19:0] E_FWAIT   = 20'b0_0_000_000_0_00_0_0_0_1_0_0_0_0_0;
    localparam logic [19:0] E_DECODE  = 20'b0_0_011_001_0_00_0_0_0_0_0_1_0_0_0;
    localparam logic [19:0] E_IMMADD  = 20'b0_1_010_001_0_00_0_0_0_0_0_1_0_0_0;
    localparam logic [19:0] E_MRD     = 20'b0_0_000_000_0_00_1_1_0_0_0_0_0_0_0;
    localparam logic [19:0] E_MRDW    = 20'b0_0_000_000_0_00_0_0_0_0_1_0_0_0_0;
    localparam logic [19:0] E_LWWB    = 20'b0_0_000_000_0_00_0_0_0_0_0_0_1_0_1;
    localparam logic [19:0] E_SW      = 20'b0_0_000_000_0_00_1_0_1_0_0_0_0_0_0;
    localparam logic [19:0] E_RT_ADD  = 20'b0_1_000_001_0_00_0_0_0_0_0_1_0_0_0;
    localparam logic [19:0] E_RT_SUB  = 20'b0_1_000_010_0_00_0_0_0_0_0_1_0_0_0;
    localparam logic [19:0] E_RT_AND  = 20'b0_1_000_011_0_00_0_0_0_0_0_1_0_0_0;
    localparam logic [19:0] E_RT_OR   = 20'b0_1_000_100_0_00_0_0_0_0_0_1_0_0_0;
    localparam logic [19:0] E_RTWB    = 20'b0_0_000_000_0_00_0_0_0_0_0_0_1_1_0;
    localparam logic [19:0] E_RTWB_RT = 20'b0_0_000_000_0_00_0_0_0_0_0_0_1_0_0;
    localparam logic [19:0] E_BEQ_T   = 20'b0_1_000_010_1_01_0_0_0_0_0_0_0_0_0;
    localparam logic [19:0] E_BEQ_N   = 20'b0_1_000_010_0_01_0_0_0_0_0_0_0_0_0;
    localparam logic [19:0] E_JUMP    = 20'b0_0_000_000_1_10_0_0_0_0_0_0_0_0_0;
    localparam logic [19:0] E_ADDMEX  = 20'b0_1_100_001_0_00_0_0_0_0_0_1_0_0_0;
    localparam logic [19:0] E_HALT    = 20'b1_0_000_000_0_00_0_0_0_0_0_0_0_0_0;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic [4:0]  st;
        logic [19:0] ex;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input logic [4:0] st, input logic [19:0] ex);
        vec_t v;
        v.op = op; v.fn = fn; v.z = z; v.st = st; v.ex = ex;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [4:0] es, input logic [19:0] eo);
        checks++;
        if (state !== es) begin
            errors++;
            $display("FAIL %s state got %0d want %0d", nm, state, es);
        end
        checks++;
        if (obs !== eo) begin
            errors++;
            $display("FAIL %s outputs got %b want %b (state %0d)", nm, obs, eo, state);
        end
        checks++;
        if ((mem_read & mem_write) || (reg_write & mem_write)) begin
            errors++;
            $display("FAIL %s strobe_excl got rd=%b wr=%b rw=%b want no overlap",
                     nm, mem_read, mem_write, reg_write);
        end
    endtask

    // Drive the instruction fields for this cycle, settle, check, advance.
    task automatic cyc(input string nm, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic [4:0] es, input logic [19:0] eo);
        opcode = op; funct = fn; zero = z;
        #1;
        chk(nm, es, eo);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; opcode = '0; funct = '0; zero = 1'b1;
        // reset state
        add(6'h00, 6'h20, 1'b0, 5'd0, E_ZERO);
        // add
        add(6'h00, 6'h20, 1'b0, 5'd1,  E_FETCH);
        add(6'h00, 6'h20, 1'b0, 5'd2,  E_FWAIT);
        add(6'h00, 6'h20, 1'b0, 5'd3,  E_DECODE);
        add(6'h00, 6'h20, 1'b0, 5'd9,  E_RT_ADD);
        add(6'h00, 6'h20, 1'b0, 5'd10, E_RTWB);
        // sub
        add(6'h00, 6'h22, 1'b1, 5'd1,  E_FETCH);
        add(6'h00, 6'h22, 1'b1, 5'd2,  E_FWAIT);
        add(6'h00, 6'h22, 1'b1, 5'd3,  E_DECODE);
        add(6'h00, 6'h22, 1'b1, 5'd9,  E_RT_SUB);
        add(6'h00, 6'h22, 1'b1, 5'd10, E_RTWB);
        // and
        add(6'h00, 6'h24, 1'b0, 5'd1,  E_FETCH);
        add(6'h00, 6'h24, 1'b0, 5'd2,  E_FWAIT);
        add(6'h00, 6'h24, 1'b0, 5'd3,  E_DECODE);
        add(6'h00, 6'h24, 1'b0, 5'd9,  E_RT_AND);
        add(6'h00, 6'h24, 1'b0, 5'd10, E_RTWB);
        // or
        add(6'h00, 6'h25, 1'b0, 5'd1,  E_FETCH);
        add(6'h00, 6'h25, 1'b0, 5'd2,  E_FWAIT);
        add(6'h00, 6'h25, 1'b0, 5'd3,  E_DECODE);
        add(6'h00, 6'h25, 1'b0, 5'd9,  E_RT_OR);
        add(6'h00, 6'h25, 1'b0, 5'd10, E_RTWB);
        // addi
        add(6'h08, 6'h3F, 1'b0, 5'd1,  E_FETCH);
        add(6'h08, 6'h3F, 1'b0, 5'd2,  E_FWAIT);
        add(6'h08, 6'h3F, 1'b0, 5'd3,  E_DECODE);
        add(6'h08, 6'h3F, 1'b0, 5'd11, E_IMMADD);
        add(6'h08, 6'h3F, 1'b0, 5'd12, E_RTWB_RT);
        // lw
        add(6'h23, 6'h00, 1'b0, 5'd1,  E_FETCH);
        add(6'h23, 6'h00, 1'b0, 5'd2,  E_FWAIT);
        add(6'h23, 6'h00, 1'b0, 5'd3,  E_DECODE);
        add(6'h23, 6'h00, 1'b0, 5'd4,  E_IMMADD);
        add(6'h23, 6'h00, 1'b0, 5'd5,  E_MRD);
        add(6'h23, 6'h00, 1'b0, 5'd6,  E_MRDW);
        add(6'h23, 6'h00, 1'b0, 5'd7,  E_LWWB);
        // addm
        add(6'h01, 6'h00, 1'b0, 5'd1,  E_FETCH);
        add(6'h01, 6'h00, 1'b0, 5'd2,  E_FWAIT);
        add(6'h01, 6'h00, 1'b0, 5'd3,  E_DECODE);
        add(6'h01, 6'h00, 1'b0, 5'd4,  E_IMMADD);
        add(6'h01, 6'h00, 1'b0, 5'd5,  E_MRD);
        add(6'h01, 6'h00, 1'b0, 5'd6,  E_MRDW);
        add(6'h01, 6'h00, 1'b0, 5'd15, E_ADDMEX);
        add(6'h01, 6'h00, 1'b0, 5'd16, E_RTWB_RT);
        // sw
        add(6'h2B, 6'h00, 1'b0, 5'd1,  E_FETCH);
        add(6'h2B, 6'h00, 1'b0, 5'd2,  E_FWAIT);
        add(6'h2B, 6'h00, 1'b0, 5'd3,  E_DECODE);
        add(6'h2B, 6'h00, 1'b0, 5'd4,  E_IMMADD);
        add(6'h2B, 6'h00, 1'b0, 5'd8,  E_SW);
        // beq taken
        add(6'h04, 6'h00, 1'b1, 5'd1,  E_FETCH);
        add(6'h04, 6'h00, 1'b1, 5'd2,  E_FWAIT);
        add(6'h04, 6'h00, 1'b1, 5'd3,  E_DECODE);
        add(6'h04, 6'h00, 1'b1, 5'd13, E_BEQ_T);
        // beq not taken
        add(6'h04, 6'h00, 1'b0, 5'd1,  E_FETCH);
        add(6'h04, 6'h00, 1'b0, 5'd2,  E_FWAIT);
        add(6'h04, 6'h00, 1'b0, 5'd3,  E_DECODE);
        add(6'h04, 6'h00, 1'b0, 5'd13, E_BEQ_N);
        // j
        add(6'h02, 6'h00, 1'b1, 5'd1,  E_FETCH);
        add(6'h02, 6'h00, 1'b1, 5'd2,  E_FWAIT);
        add(6'h02, 6'h00, 1'b1, 5'd3,  E_DECODE);
        add(6'h02, 6'h00, 1'b1, 5'd14, E_JUMP);
        // illegal opcode
        add(6'h3F, 6'h20, 1'b0, 5'd1,  E_FETCH);
        add(6'h3F, 6'h20, 1'b0, 5'd2,  E_FWAIT);
        add(6'h3F, 6'h20, 1'b0, 5'd3,  E_DECODE);
        add(6'h3F, 6'h20, 1'b0, 5'd17, E_HALT);

        repeat (3) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++)
            cyc($sformatf("vec[%0d]", i), tbl[i].op, tbl[i].fn, tbl[i].z,
                tbl[i].st, tbl[i].ex);

        // HALT holds regardless of opcode/zero until reset
        for (int i = 0; i < 12; i++)
            cyc("halt_hold_op", 6'(i * 5), 6'h20, i[0], 5'd17, E_HALT);

        reset = 1'b1;
        @(negedge clk);
        cyc("halt_reset", 6'h00, 6'h00, 1'b1, 5'd0, E_ZERO);
        reset = 1'b0;
        cyc("rt_bad_rst", 6'h00, 6'h00, 1'b0, 5'd0, E_ZERO);

        // R-type with unsupported funct
        cyc("rt_bad_f",  6'h00, 6'h00, 1'b0, 5'd1,  E_FETCH);
        cyc("rt_bad_fw", 6'h00, 6'h00, 1'b0, 5'd2,  E_FWAIT);
        cyc("rt_bad_d",  6'h00, 6'h00, 1'b0, 5'd3,  E_DECODE);
        for (int i = 0; i < 11; i++)
            cyc("rt_bad_hold", 6'h00, 6'h00, 1'b1, 5'd17, E_HALT);

        // reset held three cycles starting in LW_WB
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cyc("lwr_start", 6'h23, 6'h00, 1'b0, 5'd0, E_ZERO);
        cyc("lwr_f",   6'h23, 6'h00, 1'b0, 5'd1, E_FETCH);
        cyc("lwr_fw",  6'h23, 6'h00, 1'b0, 5'd2, E_FWAIT);
        cyc("lwr_d",   6'h23, 6'h00, 1'b0, 5'd3, E_DECODE);
        cyc("lwr_ma",  6'h23, 6'h00, 1'b0, 5'd4, E_IMMADD);
        cyc("lwr_rd",  6'h23, 6'h00, 1'b0, 5'd5, E_MRD);
        cyc("lwr_rdw", 6'h23, 6'h00, 1'b0, 5'd6, E_MRDW);
        opcode = 6'h23; zero = 1'b1;
        #1;
        chk("lwr_wb", 5'd7, E_LWWB);
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++)
            cyc("lwr_in_reset", 6'h23, 6'h00, 1'b1, 5'd0, E_ZERO);
        reset = 1'b0;
        @(negedge clk);
        cyc("lwr_release", 6'h23, 6'h00, 1'b1, 5'd1, E_FETCH);
        cyc("lwr_after",   6'h23, 6'h00, 1'b1, 5'd2, E_FWAIT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
